// File: rtl/sec32_check_encoder_if.sv
// Stream bundle between the data source, the SEC check encoder and the link.
// Carries key loading, the input word handshake and the encoded output word.
interface sec32_check_encoder_if #(
    parameter int CNT_W = 16
);
    logic             key_load;
    logic [7:0]       key_in;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [7:0]       out_check;
    logic             keyed;
    logic [CNT_W-1:0] word_cnt;

    modport master (
        output key_load, key_in, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_check, keyed, word_cnt
    );

    modport slave (
        input  key_load, key_in, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_check, keyed, word_cnt
    );
endinterface

// File: rtl/sec32_check_encoder.sv
// Keyed 8-bit check-bit generator for the c1355 32-bit SEC corrector.
// Two-stage valid/ready pipeline; check bits are masked by key_reg ^ KEY_CORRECT.
module sec32_check_encoder #(
    parameter logic [7:0] KEY_CORRECT = 8'b10100010,
    parameter int         CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sec32_check_encoder_if.slave bus
);
    typedef enum logic [1:0] {UNKEYED, RUN, REKEY} state_t;

    // Row i selects the data bits feeding parity bit i.
    localparam logic [7:0][31:0] PMASK = {
        32'h8888F0F0, 32'h44440F0F, 32'h2222FF00, 32'h111100FF,
        32'hF0F08888, 32'h0F0F4444, 32'hFF002222, 32'h00FF1111
    };

    state_t           state_q, state_d;
    logic [7:0]       key_q, key_d;
    logic [7:0]       pend_q, pend_d;
    logic             keyed_q, keyed_d;
    logic             s1_vld_q, s2_vld_q;
    logic [31:0]      s1_data_q, s2_data_q;
    logic [7:0]       s1_par_q, s1_mask_q, s2_chk_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       par;
    logic             s1_load, s2_load, in_rdy, accept, xfer;

    assign xfer    = s2_vld_q & bus.out_ready;
    assign s2_load = ~s2_vld_q | bus.out_ready;
    assign s1_load = ~s1_vld_q | s2_load;
    assign accept  = bus.in_valid & in_rdy;

    always_comb begin
        par = '0;
        for (int i = 0; i < 8; i++) begin
            par[i] = ^(bus.in_data & PMASK[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        pend_d  = pend_q;
        keyed_d = keyed_q;
        in_rdy  = 1'b0;
        case (state_q)
            UNKEYED: begin
                if (bus.key_load) begin
                    key_d   = bus.key_in;
                    keyed_d = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                in_rdy = s1_load;
                if (bus.key_load) begin
                    pend_d  = bus.key_in;
                    state_d = REKEY;
                end
            end
            REKEY: begin
                if (bus.key_load) pend_d = bus.key_in;
                // Switch keys only once no word tagged with the old mask remains.
                if (!s1_vld_q && !s2_vld_q) begin
                    key_d   = pend_d;
                    state_d = RUN;
                end
            end
            default: state_d = UNKEYED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= UNKEYED;
            key_q   <= '0;
            pend_q  <= '0;
            keyed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            pend_q  <= pend_d;
            keyed_q <= keyed_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s1_par_q  <= '0;
            s1_mask_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
            s2_chk_q  <= '0;
        end else begin
            if (s1_load) s1_vld_q <= accept;
            if (accept) begin
                s1_data_q <= bus.in_data;
                s1_par_q  <= par;
                s1_mask_q <= key_q ^ KEY_CORRECT;
            end
            if (s2_load) s2_vld_q <= s1_vld_q;
            if (s2_load && s1_vld_q) begin
                s2_data_q <= s1_data_q;
                s2_chk_q  <= s1_par_q ^ s1_mask_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (xfer) cnt_q <= cnt_q + 1'b1;
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = s2_vld_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_check = s2_chk_q;
    assign bus.keyed     = keyed_q;
    assign bus.word_cnt  = cnt_q;
endmodule

// File: tb/tb_sec32_check_encoder.sv
// Directed bench for sec32_check_encoder: a word-level scoreboard built from the
// parity index lists, plus literal expectations for the key/check-bit cases.
module tb_sec32_check_encoder;
    localparam logic [7:0] KC = 8'hA2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sec32_check_encoder_if #(.CNT_W(16)) bus ();
    sec32_check_encoder #(.KEY_CORRECT(KC), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit lat_mode = 1'b0;

    int pidx [8][12] = '{
        '{0, 4, 8, 12, 16, 17, 18, 19, 20, 21, 22, 23},
        '{1, 5, 9, 13, 24, 25, 26, 27, 28, 29, 30, 31},
        '{2, 6, 10, 14, 16, 17, 18, 19, 24, 25, 26, 27},
        '{3, 7, 11, 15, 20, 21, 22, 23, 28, 29, 30, 31},
        '{0, 1, 2, 3, 4, 5, 6, 7, 16, 20, 24, 28},
        '{8, 9, 10, 11, 12, 13, 14, 15, 17, 21, 25, 29},
        '{0, 1, 2, 3, 8, 9, 10, 11, 18, 22, 26, 30},
        '{4, 5, 6, 7, 12, 13, 14, 15, 19, 23, 27, 31}
    };

    typedef struct {
        logic [31:0] d;
        logic [7:0]  c;
        int          cyc;
    } exp_t;
    exp_t expq[$];

    logic [7:0]  cur_key = '0;
    bit          mkeyed  = 1'b0;
    logic [15:0] mcnt    = '0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_d;
    logic [7:0]  prev_c;

    function automatic logic [7:0] model_par(input logic [31:0] d);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 12; j++)
                p[i] = p[i] ^ d[pidx[i][j]];
        return p;
    endfunction

    // Receiver: syndrome over G1..G40 enabled by G41, flipping the data bit whose column matches.
    function automatic logic [31:0] c1355(input logic [40:0] g);
        logic [31:0] d;
        logic [31:0] one;
        logic [7:0]  s;
        d = g[31:0];
        s = model_par(d) ^ g[39:32];
        if (g[40] && s != 8'h00) begin
            for (int b = 0; b < 32; b++) begin
                one = 32'h1 << b;
                if (model_par(one) == s) d[b] = ~d[b];
            end
        end
        return d;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            mcnt       = '0;
            cur_key    = '0;
            mkeyed     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("word_cnt", bus.word_cnt, mcnt);
            chk("keyed", bus.keyed, mkeyed);
            if (!mkeyed) chk("unkeyed_in_ready", bus.in_ready, 1'b0);
            if (prev_stall) begin
                chk("hold_valid", bus.out_valid, 1'b1);
                chk("hold_data", bus.out_data, prev_d);
                chk("hold_check", bus.out_check, prev_c);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    chk("spurious_out", bus.out_valid, 1'b0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("out_data", bus.out_data, e.d);
                    chk("out_check", bus.out_check, e.c);
                    if (lat_mode) chk("latency", 64'(cyc - e.cyc), 64'd2);
                end
                mcnt = mcnt + 16'd1;
            end
            if (bus.in_valid && bus.in_ready)
                expq.push_back('{bus.in_data, model_par(bus.in_data) ^ (cur_key ^ KC), cyc});
            if (bus.key_load) begin
                cur_key = bus.key_in;
                mkeyed  = 1'b1;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_d     = bus.out_data;
            prev_c     = bus.out_check;
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk(nm, seen, 1'b1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nout, nfill;
        bit got;
        bus.key_load  = 1'b0;
        bus.key_in    = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // 1: no key -> nothing accepted
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1234_5678;
        repeat (20) begin
            @(negedge clk);
            chk("t1_in_ready", bus.in_ready, 1'b0);
            chk("t1_out_valid", bus.out_valid, 1'b0);
            chk("t1_keyed", bus.keyed, 1'b0);
        end
        step();
        bus.in_valid = 1'b0;

        // 2: correct key, zero syndrome at the receiver
        bus.out_ready = 1'b1;
        bus.key_in    = 8'hA2;
        bus.key_load  = 1'b1;
        step();
        bus.key_load  = 1'b0;
        step();
        lat_mode     = 1'b1;
        bus.in_data  = 32'h0000_0001;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wait_out("t2a_timeout");
        chk("t2a_check", bus.out_check, 8'h51);
        chk("t2a_c1355", c1355({1'b1, bus.out_check, bus.out_data}), 32'h0000_0001);
        step();
        bus.in_data  = 32'hFFFF_FFFF;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wait_out("t2b_timeout");
        chk("t2b_check", bus.out_check, 8'h00);
        chk("t2b_c1355", c1355({1'b1, bus.out_check, bus.out_data}), 32'hFFFF_FFFF);
        step();

        // 3: wrong key corrupts the check bits
        bus.key_in   = 8'hA3;
        bus.key_load = 1'b1;
        step();
        bus.key_load = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1'b1;
        end
        chk("t3_rekey_ready", got, 1'b1);
        step();
        bus.in_data  = 32'h0000_0000;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wait_out("t3_timeout");
        chk("t3_check", bus.out_check, 8'h01);
        chk("t3_syndrome", model_par(bus.out_data) ^ bus.out_check, 8'h01);
        step();

        // 4: full throughput, then random backpressure
        nout = 0;
        for (int i = 0; i < 16; i++) begin
            bus.in_data  = (32'h0101_0101 * 32'(i)) ^ 32'hA5A5_0000;
            bus.in_valid = 1'b1;
            @(negedge clk);
            chk("t4_in_ready", bus.in_ready, 1'b1);
            if (bus.out_valid) nout++;
            step();
        end
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.out_valid) nout++;
        end
        chk("t4_throughput", 64'(nout), 64'd16);
        step();
        lat_mode = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = $urandom;
            bus.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("t4_no_loss", 64'(expq.size()), 64'd0);
        step();

        // 5: rekey with both stages full and stalled (current key A3)
        bus.out_ready = 1'b0;
        bus.in_data   = 32'h0000_0001;
        bus.in_valid  = 1'b1;
        step();
        bus.in_data   = 32'h0000_0002;
        step();
        bus.in_valid  = 1'b0;
        bus.key_in    = 8'hA2;
        bus.key_load  = 1'b1;
        step();
        bus.key_load  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t5_stall_ready", bus.in_ready, 1'b0);
        end
        step();
        bus.out_ready = 1'b1;
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (i == 0) chk("t5_old_mask_w1", bus.out_check, 8'h50);
            if (i == 1) chk("t5_old_mask_w2", bus.out_check, 8'h53);
            if (bus.in_ready) got = 1'b1;
            else n++;
        end
        chk("t5_drain_cycles", 64'(n), 64'd3);
        step();
        lat_mode     = 1'b1;
        bus.in_data  = 32'h0000_0001;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wait_out("t5_timeout");
        chk("t5_new_key", bus.out_check, 8'h51);
        step();

        // 6: word counter wrap, then asynchronous reset mid-stream
        lat_mode = 1'b0;
        nfill = 32'hFFFF - int'(mcnt);
        bus.in_valid = 1'b1;
        repeat (nfill) begin
            bus.in_data = $urandom;
            step();
        end
        bus.in_valid = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("t6_cnt_max", bus.word_cnt, 16'hFFFF);
        step();
        bus.in_data  = 32'hCAFE_F00D;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("t6_cnt_wrap", bus.word_cnt, 16'h0000);
        step();

        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        repeat (4) begin
            bus.in_data = $urandom | 32'h1;
            step();
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_out_check", bus.out_check, 8'h0);
        chk("rst_keyed", bus.keyed, 1'b0);
        chk("rst_word_cnt", bus.word_cnt, 16'h0);
        bus.out_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_out_valid", bus.out_valid, 1'b0);
            chk("post_rst_in_ready", bus.in_ready, 1'b0);
        end
        bus.in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
